// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture front end.
//   - default source geometry and decimation factor
//   - counter and frame-buffer address widths
//   - capture FSM state encoding
//   - frame-buffer write address payload {x, y}
package cam_pkg;

    localparam int unsigned SRC_W_DEF = 640;
    localparam int unsigned SRC_H_DEF = 480;
    localparam int unsigned DEC_DEF   = 4;

    localparam int unsigned ADDR_X_W  = 8;
    localparam int unsigned ADDR_Y_W  = 7;
    localparam int unsigned ADDR_W    = ADDR_X_W + ADDR_Y_W;
    localparam int unsigned COL_W     = 11;
    localparam int unsigned ROW_W     = 10;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned PIX_W     = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        LINE      = 2'd2,
        FROZEN    = 2'd3
    } cam_state_e;

    typedef struct packed {
        logic [ADDR_X_W-1:0] x;
        logic [ADDR_Y_W-1:0] y;
    } cam_addr_t;

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer with edge detection for one camera control line.
// Ports:
//   i_clk      system clock
//   i_reset    asynchronous active-high reset
//   i_d        asynchronous input
//   o_q        synchronized level (second flop)
//   o_rise_c   one-cycle pulse: synced level 1, previous synced level 0
//   o_fall_c   one-cycle pulse: synced level 0, previous synced level 1
module cam_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_q      = r_s2;
    assign o_rise_c = r_s2 & ~r_prev;
    assign o_fall_c = ~r_s2 & r_prev;

endmodule

// File: rtl/cam_capture.sv
// Camera (OV7670-style) capture into a decimated RGB565 frame buffer.
// The camera interface is oversampled by clk: pclk/href/vref are synchronized
// and edge-detected, the data byte is delayed by the same two stages so it
// lines up with the detected pclk edge.
// Ports:
//   clk      system clock (rising edge)
//   reset    asynchronous active-high reset
//   pclk     camera pixel clock, sampled as data
//   href     camera line valid
//   vref     camera vertical sync (high during vertical blanking pulse)
//   digital  camera data byte
//   capture  snapshot request level, sampled at end of frame
//   pixel    assembled RGB565 pixel
//   wraddr   frame-buffer write address {x[7:0], y[6:0]}
//   wren     one-cycle write strobe
//   frozen   high while writes are suppressed after a snapshot
module cam_capture
    import cam_pkg::*;
#(
    parameter int unsigned SRC_W = SRC_W_DEF,
    parameter int unsigned SRC_H = SRC_H_DEF,
    parameter int unsigned DEC   = DEC_DEF     // must be a power of two
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pclk,
    input  logic                href,
    input  logic                vref,
    input  logic [BYTE_W-1:0]   digital,
    input  logic                capture,
    output logic [PIX_W-1:0]    pixel,
    output logic [ADDR_W-1:0]   wraddr,
    output logic                wren,
    output logic                frozen
);

    localparam int unsigned      DEC_SH   = $clog2(DEC);
    localparam logic [COL_W-1:0] COL_LIM  = COL_W'(SRC_W);
    localparam logic [ROW_W-1:0] ROW_LIM  = ROW_W'(SRC_H);
    localparam logic [COL_W-1:0] COL_MASK = COL_W'(DEC - 1);
    localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'(DEC - 1);

    logic w_pclk_q;
    logic w_pclk_rise;
    logic w_pclk_fall;
    logic w_href_q;
    logic w_href_rise;
    logic w_href_fall;
    logic w_vref_q;
    logic w_vref_rise;
    logic w_vref_fall;
    logic w_unused;

    logic [BYTE_W-1:0] r_dig_s1;
    logic [BYTE_W-1:0] r_dig_s2;

    cam_state_e        r_state;
    cam_state_e        w_state_nxt;
    logic [COL_W-1:0]  r_col;
    logic [COL_W-1:0]  w_col_nxt;
    logic [ROW_W-1:0]  r_row;
    logic [ROW_W-1:0]  w_row_nxt;
    logic              r_phase;
    logic              w_phase_nxt;
    logic [PIX_W-1:0]  r_pixel;
    logic [PIX_W-1:0]  w_pixel_nxt;
    cam_addr_t         r_wraddr;
    cam_addr_t         w_wraddr_nxt;
    logic              r_wren;
    logic              w_wren_nxt;
    logic              r_frozen;

    logic              w_in_window;
    logic              w_byte_c;
    cam_addr_t         w_addr_cur;
    logic [COL_W-1:0]  w_col_inc;
    logic [ROW_W-1:0]  w_row_inc;

    cam_sync u_sync_pclk (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_d      (pclk),
        .o_q      (w_pclk_q),
        .o_rise_c (w_pclk_rise),
        .o_fall_c (w_pclk_fall)
    );

    cam_sync u_sync_href (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_d      (href),
        .o_q      (w_href_q),
        .o_rise_c (w_href_rise),
        .o_fall_c (w_href_fall)
    );

    cam_sync u_sync_vref (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_d      (vref),
        .o_q      (w_vref_q),
        .o_rise_c (w_vref_rise),
        .o_fall_c (w_vref_fall)
    );

    // Only the pclk rising edge and the href/vref edges drive the capture logic
    assign w_unused = &{1'b0, w_pclk_q, w_pclk_fall, w_vref_q};

    // Data delay matching the synchronizer depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dig_s1 <= '0;
            r_dig_s2 <= '0;
        end else begin
            r_dig_s1 <= digital;
            r_dig_s2 <= r_dig_s1;
        end
    end

    // A byte is accepted only on a pclk edge while the line is valid
    assign w_byte_c = w_pclk_rise & w_href_q;

    // Pair lands on the decimated grid and inside the active image
    assign w_in_window = ((r_col & COL_MASK) == '0) &&
                         ((r_row & ROW_MASK) == '0) &&
                         (r_col < COL_LIM) &&
                         (r_row < ROW_LIM);

    assign w_addr_cur = {ADDR_X_W'(r_col >> DEC_SH), ADDR_Y_W'(r_row >> DEC_SH)};

    // Counters saturate so oversized lines/frames can never wrap back into the window
    assign w_col_inc = (r_col == '1) ? r_col : r_col + COL_W'(1);
    assign w_row_inc = (r_row == '1) ? r_row : r_row + ROW_W'(1);

    // Next-state and datapath decode
    always_comb begin
        w_state_nxt  = r_state;
        w_col_nxt    = r_col;
        w_row_nxt    = r_row;
        w_phase_nxt  = r_phase;
        w_pixel_nxt  = r_pixel;
        w_wraddr_nxt = r_wraddr;
        w_wren_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_vref_fall) begin
                    w_state_nxt = WAIT_LINE;
                    w_row_nxt   = '0;
                end
            end

            WAIT_LINE: begin
                if (w_vref_rise) begin
                    w_state_nxt = capture ? FROZEN : IDLE;
                end else if (w_href_rise) begin
                    w_state_nxt = LINE;
                    w_col_nxt   = '0;
                    w_phase_nxt = 1'b0;
                end
            end

            LINE: begin
                // Pair completion is handled before any state change so a
                // coincident vref edge still issues the final write
                if (w_byte_c) begin
                    if (!r_phase) begin
                        w_pixel_nxt = {r_dig_s2, r_pixel[BYTE_W-1:0]};
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_pixel_nxt = {r_pixel[PIX_W-1:BYTE_W], r_dig_s2};
                        w_phase_nxt = 1'b0;
                        w_col_nxt   = w_col_inc;
                        if (w_in_window) begin
                            w_wren_nxt   = 1'b1;
                            w_wraddr_nxt = w_addr_cur;
                        end
                    end
                end

                if (w_vref_rise) begin
                    w_state_nxt = capture ? FROZEN : IDLE;
                end else if (w_href_fall) begin
                    // A lone trailing high byte is dropped here
                    w_state_nxt = WAIT_LINE;
                    w_row_nxt   = w_row_inc;
                    w_phase_nxt = 1'b0;
                end
            end

            FROZEN: begin
                if (!capture) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_col    <= '0;
            r_row    <= '0;
            r_phase  <= 1'b0;
            r_pixel  <= '0;
            r_wraddr <= '0;
            r_wren   <= 1'b0;
            r_frozen <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_phase  <= w_phase_nxt;
            r_pixel  <= w_pixel_nxt;
            r_wraddr <= w_wraddr_nxt;
            r_wren   <= w_wren_nxt;
            r_frozen <= (w_state_nxt == FROZEN);
        end
    end

    assign pixel  = r_pixel;
    assign wraddr = r_wraddr;
    assign wren   = r_wren;
    assign frozen = r_frozen;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a reduced 32x16 source (8x4 output).
// Expected writes are queued as bytes are driven; observed writes are queued
// as wren pulses appear; the two queues are compared at the end of each frame.
module tb_cam_capture;

    localparam int W = 32;
    localparam int H = 16;
    localparam int D = 4;
    localparam int WR_PER_FRAME = (W / D) * (H / D);

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] pix;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pclk;
    logic        href;
    logic        vref;
    logic [7:0]  digital;
    logic        capture;
    logic [15:0] pixel;
    logic [14:0] wraddr;
    logic        wren;
    logic        frozen;

    wr_t exp_q[$];
    wr_t obs_q[$];
    wr_t last_wr;
    int  n_checks = 0;
    int  n_errors = 0;
    int  n_wren   = 0;
    int  max_x    = 0;
    int  max_y    = 0;

    cam_capture #(
        .SRC_W (W),
        .SRC_H (H),
        .DEC   (D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pclk    (pclk),
        .href    (href),
        .vref    (vref),
        .digital (digital),
        .capture (capture),
        .pixel   (pixel),
        .wraddr  (wraddr),
        .wren    (wren),
        .frozen  (frozen)
    );

    always #5 clk = ~clk;

    // Advance one clock, sampling outputs on the falling edge
    task automatic tick();
        @(negedge clk);
        if (wren === 1'b1) begin
            obs_q.push_back(wr_t'({wraddr, pixel}));
            last_wr = wr_t'({wraddr, pixel});
            n_wren++;
            if (int'(wraddr[14:7]) > max_x) max_x = int'(wraddr[14:7]);
            if (int'(wraddr[6:0]) > max_y) max_y = int'(wraddr[6:0]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " pixel"},  32'(pixel),  32'h0);
        chk({tag, " wraddr"}, 32'(wraddr), 32'h0);
        chk({tag, " wren"},   32'(wren),   32'h0);
        chk({tag, " frozen"}, 32'(frozen), 32'h0);
    endtask

    // Compare observed writes with the scoreboard and clear both
    task automatic drain(input string tag, input int exp_count);
        wr_t o;
        wr_t e;
        chk({tag, " wren count"}, 32'(n_wren), 32'(exp_count));
        chk({tag, " queue depth"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, " wraddr"}, 32'(o.addr), 32'(e.addr));
            chk({tag, " pixel"},  32'(o.pix),  32'(e.pix));
        end
        obs_q.delete();
        exp_q.delete();
        n_wren = 0;
    endtask

    task automatic vref_rise();
        vref = 1'b1;
        repeat (8) tick();
    endtask

    task automatic vref_fall();
        vref = 1'b0;
        repeat (8) tick();
    endtask

    // Drive one line of nbytes; rst_at >= 0 pulses reset before that byte
    task automatic line(input int row, input int nbytes, input bit active,
                        input bit ab, input int rst_at);
        bit         act;
        int         p;
        logic [7:0] hi;
        logic [7:0] lo;
        act  = active;
        href = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < nbytes; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                repeat (2) tick();
                chk_zero_outputs("mid-line reset");
                reset = 1'b0;
                act   = 1'b0;
                tick();
            end
            p  = i / 2;
            hi = ab ? 8'hAB : 8'(p * 7 + row);
            lo = ab ? 8'hCD : (8'hC3 ^ 8'(row + p * 3));
            digital = (i % 2 == 0) ? hi : lo;
            repeat (2) tick();
            pclk = 1'b1;
            repeat (2) tick();
            pclk = 1'b0;
            if ((i % 2 == 1) && act && (p < W) && (p % D == 0) && (row < H) && (row % D == 0))
                exp_q.push_back(wr_t'({8'(p / D), 7'(row / D), hi, lo}));
        end
        repeat (2) tick();
        href = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame_lines(input int nlines, input bit active);
        for (int r = 0; r < nlines; r++) line(r, 2 * W, active, 1'b0, -1);
    endtask

    initial begin
        int nb;
        reset   = 1'b1;
        pclk    = 1'b0;
        href    = 1'b0;
        vref    = 1'b0;
        capture = 1'b0;
        digital = 8'h00;
        repeat (4) tick();
        chk_zero_outputs("reset");
        reset = 1'b0;
        repeat (4) tick();

        // Frame A: reset mid-line in row 4, nothing written afterwards
        vref_rise();
        vref_fall();
        for (int r = 0; r < 4; r++) line(r, 2 * W, 1'b1, 1'b0, -1);
        line(4, 2 * W, 1'b1, 1'b0, 20);
        for (int r = 5; r < 8; r++) line(r, 2 * W, 1'b1, 1'b0, -1);
        vref_rise();
        drain("frame A", 11);

        // Frame B: full frame, row 0 constant bytes, odd line, oversize lines/pixels
        vref_fall();
        max_x = 0;
        max_y = 0;
        for (int r = 0; r < H + 4; r++) begin
            nb = 2 * W;
            if (r == 3) nb = 2 * W + 1;
            else if (r == 4 || r == 8 || r >= H) nb = 2 * W + 8;
            line(r, nb, 1'b1, (r == 0), -1);
        end
        vref_rise();
        chk("frame B frozen", 32'(frozen), 32'h0);
        chk("frame B last wraddr", 32'(last_wr.addr), 32'({8'(W / D - 1), 7'(H / D - 1)}));
        chk("frame B max x", 32'(max_x), 32'(W / D - 1));
        chk("frame B max y", 32'(max_y), 32'(H / D - 1));
        drain("frame B", WR_PER_FRAME);

        // Frame C: capture raised mid-frame, frame still completes
        vref_fall();
        for (int r = 0; r < H; r++) begin
            if (r == 6) capture = 1'b1;
            line(r, 2 * W, 1'b1, 1'b0, -1);
        end
        vref_rise();
        chk("frame C frozen", 32'(frozen), 32'h1);
        drain("frame C", WR_PER_FRAME);

        // Frames D, E: held frozen, no writes
        for (int f = 0; f < 2; f++) begin
            vref_fall();
            frame_lines(H, 1'b0);
            vref_rise();
            chk("frozen hold", 32'(frozen), 32'h1);
        end

        // Frame F: capture dropped mid-frame, this frame still not written
        vref_fall();
        for (int r = 0; r < H; r++) begin
            if (r == 8) begin
                capture = 1'b0;
                repeat (3) tick();
                chk("capture release frozen", 32'(frozen), 32'h0);
            end
            line(r, 2 * W, 1'b0, 1'b0, -1);
        end
        vref_rise();
        drain("frozen frames", 0);

        // Frame G: writes resume
        vref_fall();
        frame_lines(H, 1'b1);
        vref_rise();
        drain("frame G", WR_PER_FRAME);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 SHALL have parameter SRC_W, default 640, meaning camera pixels per active line.
REQ-002 SHALL have parameter SRC_H, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter DEC, default 4, meaning decimation factor in both axes (power of two); output image is 160x120.
REQ-004 SHALL have port clk  in  1  the single system clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port pclk  in  1  camera pixel clock, sampled as data.
REQ-007 SHALL have port href  in  1  camera line-valid, high during active pixels.
REQ-008 SHALL have port vref  in  1  camera vertical sync, high during vertical blanking pulse.
REQ-009 SHALL have port digital  in  8  camera data byte.
REQ-010 SHALL have port capture  in  1  snapshot request, level.
REQ-011 SHALL have port pixel  out  16  assembled RGB565 pixel.
REQ-012 SHALL have port wraddr  out  15  frame-buffer write address {x[7:0], y[6:0]}.
REQ-013 SHALL have port wren  out  1  one-cycle write strobe.
REQ-014 SHALL have port frozen  out  1  high while writes are suppressed after a snapshot.

Function
REQ-015 SHALL pass pclk, href, vref each through a 2-flop synchronizer; digital is sampled with a matching 2-stage delay.
REQ-016 SHALL detect a pclk rising edge as synced pclk=1 with previous synced pclk=0; href/vref edges are detected likewise.
REQ-017 SHALL use FSM states IDLE, WAIT_LINE, LINE, FROZEN.
REQ-018 SHALL leave IDLE only on a synced vref falling edge, entering WAIT_LINE with row=0.
REQ-019 SHALL move WAIT_LINE->LINE on href rising edge, clearing col=0 and byte phase=0.
REQ-020 SHALL, in LINE, on each pclk edge with href high, latch digital into pixel[15:8] when phase=0 and into pixel[7:0] when phase=1, then toggle phase.
REQ-021 SHALL increment col (11 bits) after each completed byte pair; pairs with col>=SRC_W are discarded.
REQ-022 SHALL move LINE->WAIT_LINE on href falling edge, incrementing row (10 bits); a pending lone high byte is discarded.
REQ-023 SHALL assert wren for exactly one clk, one clk after the edge completing a pair, iff col[1:0]==0, row[1:0]==0, col<SRC_W, row<SRC_H.
REQ-024 SHALL drive wraddr = {col/DEC [7:0], row/DEC [6:0]} and pixel stable in the wren cycle.
REQ-025 SHALL treat a vref rising edge in WAIT_LINE or LINE as end of frame: if capture=1 go to FROZEN, else go to IDLE.
REQ-026 SHALL hold frozen=1 and wren=0 in FROZEN; leave to IDLE when capture=0.
REQ-027 SHALL ignore capture changes mid-frame; only the end-of-frame sample matters, so a snapshot is always a complete frame.
REQ-028 SHALL ignore href activity while in IDLE or FROZEN.
REQ-029 SHALL, when vref edge and pair completion coincide in one clk, issue that wren before changing state.

Reset
REQ-030 SHALL on reset force state=IDLE, row=0, col=0, phase=0, pixel=0, wraddr=0, wren=0, frozen=0, synchronizer flops=0.
REQ-031 SHALL after reset mid-frame write nothing until the next vref falling edge.

Structure
REQ-032 SHALL place the state enum, SRC_W/SRC_H/DEC defaults and address widths (8/7) in package cam_pkg.
REQ-033 SHALL implement synchronizer plus edge detect as sub-module cam_sync, instantiated three times.

Verification
REQ-034 SHALL verify reset: reset mid-LINE -> all outputs 0, no wren until after next vref fall.
REQ-035 SHALL verify line 0 of 640 pairs with bytes 0xAB,0xCD -> exactly 160 wren, pixel=0xABCD, wraddr x=0..159, y=0.
REQ-036 SHALL verify full 480-line frame -> 19200 wren, last wraddr={8'd159,7'd119}; lines with row%4!=0 produce none.
REQ-037 SHALL verify line with 641 bytes (odd) -> final lone byte discarded, no extra wren, next line starts phase=0.
REQ-038 SHALL verify capture=1 raised mid-frame -> frame completes, frozen=1 at vref rise, zero wren for next 2 frames; capture=0 -> writes resume on the following frame.
REQ-039 SHALL verify lines 480+ and pixels 640+ injected -> no wren, wraddr never exceeds {159,119}.
